// File: rtl/ireq_arbiter.sv
// Packet-atomic round-robin arbiter (DB vs NWRITE/NREAD) onto the SRIO ireq stream with length policing.
// Optional IREQ_ARB_DB_PRIO_EN: doorbell source gets strict priority on ties instead of round-robin.
module ireq_arbiter #(
  parameter int MAX_BEATS = 33,
  parameter int CNT_W     = 16
) (
  input  logic             log_clk,
  input  logic             log_rst,
  input  logic             db_tvalid,
  output logic             db_tready,
  input  logic             db_tlast,
  input  logic [63:0]      db_tdata,
  input  logic [7:0]       db_tkeep,
  input  logic [31:0]      db_tuser,
  input  logic             nw_tvalid,
  output logic             nw_tready,
  input  logic             nw_tlast,
  input  logic [63:0]      nw_tdata,
  input  logic [7:0]       nw_tkeep,
  input  logic [31:0]      nw_tuser,
  output logic             ireq_tvalid_o,
  input  logic             ireq_tready_in,
  output logic             ireq_tlast_o,
  output logic [63:0]      ireq_tdata_o,
  output logic [7:0]       ireq_tkeep_o,
  output logic [31:0]      ireq_tuser_o,
  input  logic             err_clr,
  output logic             len_err,
  output logic [CNT_W-1:0] db_pkt_cnt,
  output logic [CNT_W-1:0] nw_pkt_cnt
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_GNT_DB, S_GNT_NW, S_DRAIN} state_t;

  state_t           r_state;
  logic             r_drain_nw;
  logic             r_last_nw;
  logic [BW-1:0]    r_beat_cnt;
  logic             r_len_err;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_nw_cnt;

  logic w_sel_db, w_sel_nw, w_granted;
  logic w_src_vld, w_src_last, w_at_max, w_acc, w_pkt_end, w_len_set;
  logic w_drain_end, w_pick_db;

  assign w_sel_db   = (r_state == S_GNT_DB);
  assign w_sel_nw   = (r_state == S_GNT_NW);
  assign w_granted  = w_sel_db | w_sel_nw;
  assign w_src_vld  = w_sel_db ? db_tvalid : nw_tvalid;
  assign w_src_last = w_sel_db ? db_tlast  : nw_tlast;
  assign w_at_max   = (r_beat_cnt == BW'(MAX_BEATS - 1));

  // Payload is a pure mux of the granted source; zero whenever nothing is granted.
  assign ireq_tvalid_o = w_granted & w_src_vld;
  assign ireq_tlast_o  = w_granted & (w_src_last | w_at_max);
  assign ireq_tdata_o  = w_sel_db ? db_tdata : (w_sel_nw ? nw_tdata : 64'd0);
  assign ireq_tkeep_o  = w_sel_db ? db_tkeep : (w_sel_nw ? nw_tkeep : 8'd0);
  assign ireq_tuser_o  = w_sel_db ? db_tuser : (w_sel_nw ? nw_tuser : 32'd0);

  assign db_tready = (w_sel_db & ireq_tready_in) | ((r_state == S_DRAIN) & ~r_drain_nw);
  assign nw_tready = (w_sel_nw & ireq_tready_in) | ((r_state == S_DRAIN) &  r_drain_nw);

  assign w_acc       = ireq_tvalid_o & ireq_tready_in;
  assign w_pkt_end   = w_acc & (w_src_last | w_at_max);
  assign w_len_set   = w_acc & w_at_max & ~w_src_last;
  assign w_drain_end = (r_state == S_DRAIN) &
                       (r_drain_nw ? (nw_tvalid & nw_tlast) : (db_tvalid & db_tlast));

`ifdef IREQ_ARB_DB_PRIO_EN
  assign w_pick_db = db_tvalid;
`else
  // On a tie the doorbell wins only if the data path was served last.
  assign w_pick_db = db_tvalid & (~nw_tvalid | r_last_nw);
`endif

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_state    <= S_IDLE;
      r_drain_nw <= 1'b0;
      r_last_nw  <= 1'b1;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
      r_db_cnt   <= '0;
      r_nw_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_db)      r_state <= S_GNT_DB;
          else if (nw_tvalid) r_state <= S_GNT_NW;
        end
        S_GNT_DB, S_GNT_NW: begin
          if (w_pkt_end) begin
            r_beat_cnt <= '0;
            r_last_nw  <= w_sel_nw;
            if (w_sel_db) r_db_cnt <= r_db_cnt + CNT_W'(1);
            else          r_nw_cnt <= r_nw_cnt + CNT_W'(1);
            if (w_src_last) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_DRAIN;
              r_drain_nw <= w_sel_nw;
            end
          end else if (w_acc) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_end) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_len_set)    r_len_err <= 1'b1;
      else if (err_clr) r_len_err <= 1'b0;
    end
  end

  assign len_err    = r_len_err;
  assign db_pkt_cnt = r_db_cnt;
  assign nw_pkt_cnt = r_nw_cnt;

endmodule

// File: tb/tb_ireq_arbiter.sv
// Directed bench for ireq_arbiter: vector table for grant/backpressure/tie cases, hand sequences for truncation and reset.
module tb_ireq_arbiter;

  logic        log_clk = 1'b0;
  logic        log_rst;
  logic        db_tvalid, db_tready, db_tlast;
  logic [63:0] db_tdata;
  logic [7:0]  db_tkeep;
  logic [31:0] db_tuser;
  logic        nw_tvalid, nw_tready, nw_tlast;
  logic [63:0] nw_tdata;
  logic [7:0]  nw_tkeep;
  logic [31:0] nw_tuser;
  logic        ireq_tvalid_o, ireq_tready_in, ireq_tlast_o;
  logic [63:0] ireq_tdata_o;
  logic [7:0]  ireq_tkeep_o;
  logic [31:0] ireq_tuser_o;
  logic        err_clr, len_err;
  logic [15:0] db_pkt_cnt, nw_pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 log_clk = ~log_clk;

  ireq_arbiter #(.MAX_BEATS(33), .CNT_W(16)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .db_tvalid(db_tvalid), .db_tready(db_tready), .db_tlast(db_tlast),
    .db_tdata(db_tdata), .db_tkeep(db_tkeep), .db_tuser(db_tuser),
    .nw_tvalid(nw_tvalid), .nw_tready(nw_tready), .nw_tlast(nw_tlast),
    .nw_tdata(nw_tdata), .nw_tkeep(nw_tkeep), .nw_tuser(nw_tuser),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in), .ireq_tlast_o(ireq_tlast_o),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
    .err_clr(err_clr), .len_err(len_err),
    .db_pkt_cnt(db_pkt_cnt), .nw_pkt_cnt(nw_pkt_cnt)
  );

  localparam logic [7:0]  DB_KEEP = 8'hFF;
  localparam logic [31:0] DB_USER = 32'h0001_0002;
  localparam logic [7:0]  NW_KEEP = 8'h0F;
  localparam logic [31:0] NW_USER = 32'h0003_0004;
  localparam logic [63:0] D1 = 64'h00A0_2000_0101_0000;

  typedef struct {
    logic        db_v, db_l;
    logic [63:0] db_d;
    logic        nw_v, nw_l;
    logic [63:0] nw_d;
    logic        rdy, clr;
    logic        e_v, e_l;
    logic [1:0]  e_src;  // 0 none, 1 DB, 2 NW
    logic        e_dbr, e_nwr, e_err;
    logic [15:0] e_dbc, e_nwc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dbv, input logic dbl, input logic [63:0] dbd,
                              input logic nwv, input logic nwl, input logic [63:0] nwd,
                              input logic rdy, input logic clr,
                              input logic ev, input logic el, input logic [1:0] esrc,
                              input logic edbr, input logic enwr, input logic eerr,
                              input logic [15:0] edbc, input logic [15:0] enwc);
    vec_t v;
    v.db_v = dbv; v.db_l = dbl; v.db_d = dbd;
    v.nw_v = nwv; v.nw_l = nwl; v.nw_d = nwd;
    v.rdy = rdy; v.clr = clr;
    v.e_v = ev; v.e_l = el; v.e_src = esrc;
    v.e_dbr = edbr; v.e_nwr = enwr; v.e_err = eerr;
    v.e_dbc = edbc; v.e_nwc = enwc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_vld"},  {63'd0, ireq_tvalid_o}, 64'd0);
    chk({nm, "_last"}, {63'd0, ireq_tlast_o}, 64'd0);
    chk({nm, "_data"}, ireq_tdata_o, 64'd0);
    chk({nm, "_keep"}, {56'd0, ireq_tkeep_o}, 64'd0);
    chk({nm, "_user"}, {32'd0, ireq_tuser_o}, 64'd0);
    chk({nm, "_dbrdy"}, {63'd0, db_tready}, 64'd0);
    chk({nm, "_nwrdy"}, {63'd0, nw_tready}, 64'd0);
  endtask

  task automatic overlong(input int nbeats, input logic hold_clr, input logic [15:0] exp_nwc);
    int fwd;
    fwd = 0;
    @(negedge log_clk);
    nw_tvalid = 1'b1; nw_tlast = 1'b0; nw_tdata = 64'd0; ireq_tready_in = 1'b1; err_clr = hold_clr;
    #1 chk("ovl_idle_vld", {63'd0, ireq_tvalid_o}, 64'd0);
    for (int i = 1; i <= nbeats; i++) begin
      @(negedge log_clk);
      nw_tdata = 64'(i);
      nw_tlast = (i == nbeats);
      #1;
      if (ireq_tvalid_o && ireq_tready_in) fwd++;
      if (i <= 33) begin
        chk($sformatf("ovl_b%0d_vld", i), {63'd0, ireq_tvalid_o}, 64'd1);
        chk($sformatf("ovl_b%0d_data", i), ireq_tdata_o, 64'(i));
        chk($sformatf("ovl_b%0d_last", i), {63'd0, ireq_tlast_o}, {63'd0, i == 33});
        chk($sformatf("ovl_b%0d_err", i), {63'd0, len_err}, 64'd0);
      end else begin
        chk($sformatf("ovl_b%0d_vld", i), {63'd0, ireq_tvalid_o}, 64'd0);
        chk($sformatf("ovl_b%0d_nwrdy", i), {63'd0, nw_tready}, 64'd1);
        chk($sformatf("ovl_b%0d_dbrdy", i), {63'd0, db_tready}, 64'd0);
        chk($sformatf("ovl_b%0d_err", i), {63'd0, len_err}, {63'd0, (i == 34) | ~hold_clr});
      end
    end
    @(negedge log_clk);
    nw_tvalid = 1'b0; nw_tlast = 1'b0; err_clr = 1'b0;
    #1;
    chk("ovl_fwd_beats", 64'(fwd), 64'd33);
    chk("ovl_end_vld", {63'd0, ireq_tvalid_o}, 64'd0);
    chk("ovl_end_err", {63'd0, len_err}, {63'd0, ~hold_clr});
    chk("ovl_nw_cnt", {48'd0, nw_pkt_cnt}, {48'd0, exp_nwc});
  endtask

  initial begin
    log_rst = 1'b1;
    db_tvalid = 0; db_tlast = 0; db_tdata = '0; db_tkeep = DB_KEEP; db_tuser = DB_USER;
    nw_tvalid = 0; nw_tlast = 0; nw_tdata = '0; nw_tkeep = NW_KEEP; nw_tuser = NW_USER;
    ireq_tready_in = 1'b0; err_clr = 1'b0;

    //            dbv dbl dbd    nwv nwl nwd    rdy clr  v  l src dbr nwr err dbc nwc
    vecs.push_back(mk(0, 0, 64'h0, 0, 0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, D1,    0, 0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, D1,    0, 0, 64'h0,  1, 0,  1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0, 0, 0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 64'hA1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 64'hA1, 1, 0,  1, 0, 2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 64'hA2, 0, 0,  1, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 64'hA2, 0, 0,  1, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 0, 64'hA2, 1, 0,  1, 0, 2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 1, 1, 64'hA3, 1, 0,  1, 1, 2, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 64'h0, 0, 0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 64'hB2, 1, 0, 64'hC4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 64'hB2, 1, 0, 64'hC4, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 64'hB3, 1, 0, 64'hC4, 1, 0, 1, 1, 1, 1, 0, 0, 1, 1));
`ifdef IREQ_ARB_DB_PRIO_EN
    vecs.push_back(mk(1, 1, 64'hB4, 1, 0, 64'hC4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 64'hB4, 1, 0, 64'hC4, 1, 0, 1, 1, 1, 1, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 64'h0,  1, 0, 64'hC4, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 64'h0,  1, 0, 64'hC4, 1, 0, 1, 0, 2, 0, 1, 0, 3, 1));
    vecs.push_back(mk(0, 0, 64'h0,  1, 1, 64'hC5, 1, 0, 1, 1, 2, 0, 1, 0, 3, 1));
`else
    vecs.push_back(mk(1, 1, 64'hB4, 1, 0, 64'hC4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 64'hB4, 1, 0, 64'hC4, 1, 0, 1, 0, 2, 0, 1, 0, 2, 1));
    vecs.push_back(mk(1, 1, 64'hB4, 1, 1, 64'hC5, 1, 0, 1, 1, 2, 0, 1, 0, 2, 1));
    vecs.push_back(mk(1, 1, 64'hB4, 0, 0, 64'h0,  1, 0, 0, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1, 64'hB4, 0, 0, 64'h0,  1, 0, 1, 1, 1, 1, 0, 0, 2, 2));
`endif
    vecs.push_back(mk(0, 0, 64'h0, 0, 0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 0, 3, 2));

    repeat (2) @(negedge log_clk);
    #1;
    chk_idle_outputs("rst");
    chk("rst_err", {63'd0, len_err}, 64'd0);
    chk("rst_dbc", {48'd0, db_pkt_cnt}, 64'd0);
    chk("rst_nwc", {48'd0, nw_pkt_cnt}, 64'd0);
    @(negedge log_clk);
    log_rst = 1'b0;

    foreach (vecs[i]) begin
      logic [63:0] e_d;
      logic [7:0]  e_k;
      logic [31:0] e_u;
      @(negedge log_clk);
      db_tvalid = vecs[i].db_v; db_tlast = vecs[i].db_l; db_tdata = vecs[i].db_d;
      nw_tvalid = vecs[i].nw_v; nw_tlast = vecs[i].nw_l; nw_tdata = vecs[i].nw_d;
      ireq_tready_in = vecs[i].rdy; err_clr = vecs[i].clr;
      e_d = (vecs[i].e_src == 2'd1) ? vecs[i].db_d : (vecs[i].e_src == 2'd2) ? vecs[i].nw_d : 64'd0;
      e_k = (vecs[i].e_src == 2'd1) ? DB_KEEP : (vecs[i].e_src == 2'd2) ? NW_KEEP : 8'd0;
      e_u = (vecs[i].e_src == 2'd1) ? DB_USER : (vecs[i].e_src == 2'd2) ? NW_USER : 32'd0;
      #1;
      chk($sformatf("v%0d_vld", i),  {63'd0, ireq_tvalid_o}, {63'd0, vecs[i].e_v});
      chk($sformatf("v%0d_last", i), {63'd0, ireq_tlast_o},  {63'd0, vecs[i].e_l});
      chk($sformatf("v%0d_data", i), ireq_tdata_o, e_d);
      chk($sformatf("v%0d_keep", i), {56'd0, ireq_tkeep_o}, {56'd0, e_k});
      chk($sformatf("v%0d_user", i), {32'd0, ireq_tuser_o}, {32'd0, e_u});
      chk($sformatf("v%0d_dbrdy", i), {63'd0, db_tready}, {63'd0, vecs[i].e_dbr});
      chk($sformatf("v%0d_nwrdy", i), {63'd0, nw_tready}, {63'd0, vecs[i].e_nwr});
      chk($sformatf("v%0d_err", i),   {63'd0, len_err},   {63'd0, vecs[i].e_err});
      chk($sformatf("v%0d_dbc", i),   {48'd0, db_pkt_cnt}, {48'd0, vecs[i].e_dbc});
      chk($sformatf("v%0d_nwc", i),   {48'd0, nw_pkt_cnt}, {48'd0, vecs[i].e_nwc});
    end

    // 40-beat packet truncated at 33, then an err_clr pulse clears the flag.
    overlong(40, 1'b0, 16'd3);
    @(negedge log_clk);
    err_clr = 1'b1;
    #1 chk("clr_before", {63'd0, len_err}, 64'd1);
    @(negedge log_clk);
    err_clr = 1'b0;
    #1 chk("clr_after", {63'd0, len_err}, 64'd0);

    // err_clr held through truncation: set wins on that cycle, clear applies afterwards.
    overlong(34, 1'b1, 16'd4);

    // Reset on beat 2 of a 4-beat DB packet.
    @(negedge log_clk);
    db_tvalid = 1'b1; db_tlast = 1'b0; db_tdata = 64'hE1; ireq_tready_in = 1'b1;
    #1 chk("mrst_idle_vld", {63'd0, ireq_tvalid_o}, 64'd0);
    @(negedge log_clk);
    #1 chk("mrst_b1_data", ireq_tdata_o, 64'hE1);
    @(negedge log_clk);
    db_tdata = 64'hE2; log_rst = 1'b1;
    #1 chk("mrst_b2_data", ireq_tdata_o, 64'hE2);
    @(negedge log_clk);
    log_rst = 1'b0;
    db_tlast = 1'b1; db_tdata = 64'hF1;
    nw_tvalid = 1'b1; nw_tlast = 1'b1; nw_tdata = 64'hF2;
    #1;
    chk_idle_outputs("mrst");
    chk("mrst_err", {63'd0, len_err}, 64'd0);
    chk("mrst_dbc", {48'd0, db_pkt_cnt}, 64'd0);
    chk("mrst_nwc", {48'd0, nw_pkt_cnt}, 64'd0);
    @(negedge log_clk);
    #1;
    chk("post_tie_vld", {63'd0, ireq_tvalid_o}, 64'd1);
    chk("post_tie_data", ireq_tdata_o, 64'hF1);
    chk("post_tie_user", {32'd0, ireq_tuser_o}, {32'd0, DB_USER});
    @(negedge log_clk);
    db_tvalid = 1'b0;
    #1;
    chk("post_bubble_vld", {63'd0, ireq_tvalid_o}, 64'd0);
    chk("post_dbc", {48'd0, db_pkt_cnt}, 64'd1);
    @(negedge log_clk);
    #1;
    chk("post_nw_vld", {63'd0, ireq_tvalid_o}, 64'd1);
    chk("post_nw_data", ireq_tdata_o, 64'hF2);
    @(negedge log_clk);
    nw_tvalid = 1'b0; nw_tlast = 1'b0;
    #1;
    chk("post_nwc", {48'd0, nw_pkt_cnt}, 64'd1);
    chk("post_end_vld", {63'd0, ireq_tvalid_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ireq_arbiter.md
# ireq_arbiter

Packet-granular two-way arbiter that shares the single SRIO initiator-request (ireq) AXI4-Stream channel between the doorbell requester and the NWRITE/NREAD data-path requester. A packet is granted atomically, from first beat to the `tlast` handshake, and is never interleaved with the other source. The arbiter also polices packet length, truncating and draining over-long packets, and keeps per-source packet counters for self-check firmware.

## Interface
Parameters:
- `MAX_BEATS`, default 33: maximum beats per packet (1 header + 32 × 8-byte payload).
- `CNT_W`, default 16: width of the per-source packet counters.

Ports:
- `log_clk` in 1: single clock for all logic.
- `log_rst` in 1: reset, synchronous, active-high.
- `db_tvalid` / `db_tready` / `db_tlast` (in / out / in, 1 each): doorbell source handshake.
- `db_tdata` in 64, `db_tkeep` in 8, `db_tuser` in 32: doorbell source payload; `tuser` is {src_id, des_id}.
- `nw_tvalid` / `nw_tready` / `nw_tlast` (in / out / in, 1 each): data-path source handshake.
- `nw_tdata` in 64, `nw_tkeep` in 8, `nw_tuser` in 32: data-path source payload.
- `ireq_tvalid_o` out 1, `ireq_tready_in` in 1, `ireq_tlast_o` out 1: request channel to the SRIO core.
- `ireq_tdata_o` out 64, `ireq_tkeep_o` out 8, `ireq_tuser_o` out 32: request channel payload.
- `err_clr` in 1: clears `len_err`.
- `len_err` out 1: sticky flag, set when an over-long packet was truncated.
- `db_pkt_cnt` out CNT_W, `nw_pkt_cnt` out CNT_W: packets forwarded per source.

## Operation
- States: IDLE, GNT_DB, GNT_NW, DRAIN.
- **IDLE**
  - All ireq outputs are 0 and both source treadys are 0.
  - If exactly one source has tvalid=1, grant it next cycle.
  - If both have tvalid=1, round-robin: grant the source not granted last.
  - `last_gnt` resets to NW, so the DB source wins the first tie.
- **GNT_x**
  - The selected source's tvalid, tlast, tdata, tkeep and tuser drive ireq combinationally. `x_tready` equals `ireq_tready_in`. The other source's tready is 0.
  - `beat_cnt` increments on each accepted beat (tvalid & tready).
  - Accepted beat with tlast=1: increment `x_pkt_cnt` (wraps at 2^CNT_W), update `last_gnt`, clear `beat_cnt`, go to IDLE.
  - Accepted beat with `beat_cnt == MAX_BEATS-1` and source tlast=0:
    - force `ireq_tlast_o`=1 on that beat;
    - set `len_err`;
    - increment `x_pkt_cnt` and update `last_gnt`;
    - go to DRAIN.
- **DRAIN**
  - `ireq_tvalid_o`=0 and the drained source's tready=1; beats are discarded.
  - Return to IDLE on that source's tvalid & tlast.
- **len_err**
  - Set has priority over `err_clr` in the same cycle.
  - `err_clr` clears it otherwise.
- **Reset mid-packet:** state → IDLE, counters and `len_err` → 0, `beat_cnt` → 0, `last_gnt` → NW. Any partially sent packet is abandoned; the SRIO core is reset by the same `log_rst`.

## Timing
- Reset values: `ireq_tvalid_o`, `ireq_tlast_o`, `ireq_tdata_o`, `ireq_tkeep_o`, `ireq_tuser_o`, `db_tready`, `nw_tready` = 0; `len_err` = 0; `db_pkt_cnt` = `nw_pkt_cnt` = 0.
- Grant latency: source tvalid sampled in IDLE at cycle N; the first beat is presented on ireq at cycle N+1.
- Data path latency is 0 cycles; payload is not registered.
- There is one IDLE bubble cycle after every packet's final handshake. Peak back-to-back throughput is therefore L/(L+1) for L-beat packets.
- While granted, the ireq outputs follow the source exactly, so AXI-Stream rules (tvalid held until tready, payload stable) are inherited from the source.
- Counter and `len_err` updates are visible the cycle after the causing handshake.

## Configuration
- `IREQ_ARB_DB_PRIO_EN` defined:
  - In IDLE, the DB source has strict priority over NW when both are valid.
  - `last_gnt` is ignored for decisions but is still updated.
- Not defined: round-robin as described in Operation.
- Packet atomicity, truncation and the counters are identical in both builds.

## Test plan
- **Single doorbell:** DB sends 1 beat (tdata 0x00A0_2000_0101_0000, tkeep 0xFF, tuser 0x0001_0002, tlast=1) with `ireq_tready_in`=1 → ireq shows that beat exactly 1 cycle after DB tvalid rises; `db_pkt_cnt`=1.
- **Tie round-robin, macro off:** DB and NW both valid from reset, each sending a 4-beat packet repeatedly → output order DB, NW, DB, NW; no interleaving within any packet; 1 idle cycle between packets.
- **Tie, macro on:** same stimulus → DB packets continuously; NW starved until DB drops tvalid, then NW is granted on the next IDLE cycle.
- **Backpressure:** `ireq_tready_in` toggling 1,0,0,1 during a 3-beat NW packet → NW beats held stable; exactly 3 beats accepted; `nw_tready` mirrors `ireq_tready_in`; `db_tready` stays 0.
- **Over-long packet:** NW sends 40 beats with tlast on beat 40 → ireq forwards 33 beats with tlast on beat 33; beats 34–40 are drained with `ireq_tvalid_o`=0; `len_err`=1 until `err_clr` pulses; `nw_pkt_cnt`=1.
- **Reset mid-packet:** `log_rst` pulsed on beat 2 of a 4-beat DB packet → next cycle all outputs and counters are 0 and state is IDLE; a new DB packet afterwards is forwarded normally.
